// File: rtl/sum_pkg.sv
// Shared constants for the sum-of-1-to-N controller/datapath pair:
// default sizing and the controller state encoding.
package sum_pkg;

    localparam int SUM_N_LIMIT = 100;
    localparam int SUM_CNT_W   = 7;
    localparam int SUM_SUM_W   = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10
    } sum_state_e;

endpackage : sum_pkg

// File: rtl/sum_acc.sv
// Accumulator for sum_datapath: SUM_W adder with carry detect and a sticky overflow flag.
// Build option SUM_DATAPATH_SATURATE_EN clamps the sum at all-ones on carry instead of wrapping.
module sum_acc
    import sum_pkg::*;
#(
    parameter int SUM_W = SUM_SUM_W,
    parameter int ADD_W = SUM_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [ADD_W-1:0] addend,
    output logic [SUM_W-1:0] sum,
    output logic             overflow
);

    logic [SUM_W-1:0] sum_d, sum_q;
    logic             overflow_d, overflow_q;
    logic [SUM_W:0]   add_full_s;

    // Next-state for the accumulator; clear beats enable.
    always_comb begin
        add_full_s = {1'b0, sum_q} + (SUM_W+1)'(addend);
        sum_d      = sum_q;
        overflow_d = overflow_q;
        if (clr) begin
            sum_d      = '0;
            overflow_d = 1'b0;
        end else if (en) begin
            if (add_full_s[SUM_W]) begin
`ifdef SUM_DATAPATH_SATURATE_EN
                sum_d = '1;
`else
                sum_d = add_full_s[SUM_W-1:0];
`endif
                overflow_d = 1'b1;
            end else begin
                sum_d = add_full_s[SUM_W-1:0];
            end
        end else begin
            sum_d      = sum_q;
            overflow_d = overflow_q;
        end
    end

    // Accumulator and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            overflow_q <= overflow_d;
        end
    end

    assign sum      = sum_q;
    assign overflow = overflow_q;

endmodule : sum_acc

// File: rtl/sum_datapath.sv
// Datapath of the sum-of-1-to-N engine: saturating counter, done compare and accumulator.
// Optional build macro: SUM_DATAPATH_SATURATE_EN (accumulator saturates instead of wrapping).
module sum_datapath
    import sum_pkg::*;
#(
    parameter int N_LIMIT = SUM_N_LIMIT,
    parameter int CNT_W   = SUM_CNT_W,
    parameter int SUM_W   = SUM_SUM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_sum,
    input  logic             ld_counter,
    input  logic             en_sum,
    input  logic             en_counter,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic [SUM_W-1:0] sum,
    output logic             overflow
);

    if ((N_LIMIT < 1) || (N_LIMIT >= (2 ** CNT_W))) begin : g_bad_limit
        $fatal(1, "sum_datapath: N_LIMIT must lie in 1 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(N_LIMIT);

    logic [CNT_W-1:0] count_d, count_q;
    logic             done_s;

    assign done_s = (count_q == LIMIT_C);

    // Counter next-state: load beats increment, increment stops at the limit.
    always_comb begin
        count_d = count_q;
        if (ld_counter) begin
            count_d = CNT_W'(1);
        end else if (en_counter && !done_s) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= CNT_W'(1);
        end else begin
            count_q <= count_d;
        end
    end

    sum_acc #(
        .SUM_W (SUM_W),
        .ADD_W (CNT_W)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (ld_sum),
        .en       (en_sum),
        .addend   (count_q),
        .sum      (sum),
        .overflow (overflow)
    );

    assign done  = done_s;
    assign count = count_q;

endmodule : sum_datapath

// File: doc/sum_datapath.md
Name: sum_datapath

Overview:
- Datapath partner of the sum-of-1-to-N controller. It receives the controller's ld_sum, ld_counter, en_sum and en_counter strobes, and drives back the done status.
- Holds the running counter and accumulator.
- Presents the final sum plus an overflow status to the surrounding top level.

Parameters:
- N_LIMIT, 100, last term added; the result is the sum of 1..N_LIMIT; legal range 1 to 2^CNT_W-1.
- CNT_W, 7, counter width in bits.
- SUM_W, 13, accumulator width in bits; the default holds 5050.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- ld_sum  in  1  load accumulator with 0
- ld_counter  in  1  load counter with 1
- en_sum  in  1  accumulate the counter into the sum this cycle
- en_counter  in  1  increment the counter this cycle
- done  out  1  counter currently equals N_LIMIT; combinational from the counter register
- count  out  CNT_W  current counter value
- sum  out  SUM_W  current accumulator value
- overflow  out  1  sticky: the accumulator carried out of SUM_W bits since the last ld_sum or reset

Behaviour:
- Reset (rst high at a clk edge) sets count=1, sum=0, overflow=0. Consequently done=0, unless N_LIMIT=1, in which case done=1.
- Register updates happen on the rising edge only. Strobes are sampled every cycle and need no handshake.
- Counter priority:
  - rst
  - ld_counter: count <= 1
  - en_counter && !done: count <= count+1
  - otherwise hold
- Accumulator priority:
  - rst
  - ld_sum: sum <= 0, overflow <= 0
  - en_sum: sum <= sum + zero-extend(count), modulo 2^SUM_W; on carry-out, overflow <= 1
  - otherwise hold
- en_sum is honoured while done=1, so the final term N_LIMIT is added. en_counter is ignored while done=1, so count saturates at N_LIMIT and never wraps.
- done = (count == N_LIMIT), with zero latency.
  - With the controller asserting both enables each COUNT cycle, the sequence is: N_LIMIT COUNT cycles → sum = N_LIMIT*(N_LIMIT+1)/2 one edge after done first rises; controller is then in DONE with enables low.
  - Sum and count then hold indefinitely.
- Strobe corner cases:
  - en_sum without en_counter adds the same count repeatedly.
  - en_counter without en_sum advances the count without adding.
  - ld and en asserted together: ld wins for that register only.
- Reset mid-operation: everything returns to its reset values in the same edge, regardless of strobes.
- Elaboration check: N_LIMIT < 1 or N_LIMIT ≥ 2^CNT_W is a fatal elaboration error.

Optional Feature:
- Macro: SUM_DATAPATH_SATURATE_EN.
- Defined: on carry-out, sum <= all-ones (2^SUM_W-1) and overflow <= 1. Further en_sum cycles keep sum at all-ones until ld_sum or rst.
- Undefined: modulo wrap as above; overflow is still flagged.
- Port list is identical in both builds.

Decomposition:
- Package sum_pkg:
  - default constants SUM_N_LIMIT=100, SUM_CNT_W=7, SUM_SUM_W=13
  - the controller state encoding constants (IDLE=2'b00, COUNT=2'b01, DONE=2'b10), so controller and datapath benches share them
- One sub-module, sum_acc:
  - contains the SUM_W adder, carry detect, optional saturation, and the sticky overflow register
  - interface: clk, rst, clr, en, addend, sum, overflow
- The counter and done compare stay in sum_datapath.

Test Plan:
- Reset with defaults → count=1, sum=0, overflow=0, done=0. Pulse ld_sum and ld_counter together for one cycle → same values.
- Defaults; after load, assert en_sum and en_counter continuously → done rises after 99 enabled cycles with count=100. One edge later sum=5050 (0x13BA), count holds 100, overflow=0.
- Keep both enables high for 10 more cycles past done → count stays 100, sum grows by 100 per cycle (6050 after 10).
  - This confirms that only en_counter is gated by done.
- SUM_W=8, N_LIMIT=100, full run:
  - without macro → overflow=1 and sum=5050 mod 256=186
  - with SUM_DATAPATH_SATURATE_EN → sum=255, overflow=1
- Assert rst while count=37 mid-run with enables high → next edge count=1, sum=0, overflow=0.
- Assert ld_sum together with en_sum at count=5 → sum=0, not 5; count still increments to 6 if en_counter is high.
- Repeat the default scenario with the controller instance connected → finish asserts and sum=5050.
